// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter for the single-port data memory: pipeline MEM stage and debug/loader.
// Round-robin on conflicts, bounded debug lock, one-cycle registered read responses.
module data_memory_arbiter #(
  parameter int LOCK_LIMIT       = 16,
  parameter int LOCK_COUNT_WIDTH = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipeRequest,
  input  logic [31:0] pipeAddress,
  input  logic [1:0]  pipeWriteType,
  input  logic [2:0]  pipeExtractExtendType,
  input  logic [31:0] pipeDataWrite,
  output logic        pipeGrant,
  output logic        pipeResponseValid,
  output logic [31:0] pipeDataRead,
  input  logic        debugRequest,
  input  logic [31:0] debugAddress,
  input  logic [1:0]  debugWriteType,
  input  logic [2:0]  debugExtractExtendType,
  input  logic [31:0] debugDataWrite,
  input  logic        debugLock,
  output logic        debugGrant,
  output logic        debugResponseValid,
  output logic [31:0] debugDataRead,
  output logic [31:0] memAddress,
  output logic [1:0]  memWriteType,
  output logic [2:0]  memExtractExtendType,
  output logic [31:0] memDataWrite,
  input  logic [31:0] memDataRead
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic SIDE_PIPE  = 1'b0;
  localparam logic SIDE_DEBUG = 1'b1;
  localparam logic [LOCK_COUNT_WIDTH-1:0] LIMIT = LOCK_COUNT_WIDTH'(LOCK_LIMIT);
  localparam logic [LOCK_COUNT_WIDTH-1:0] ONE   = LOCK_COUNT_WIDTH'(1);

  state_t                      state;
  logic                        last_grant;
  logic [LOCK_COUNT_WIDTH-1:0] lock_count;
  logic                        pipe_sel;
  logic                        debug_sel;

  // Grant decision for the current cycle; at most one side is ever selected.
  always_comb begin
    pipe_sel  = 1'b0;
    debug_sel = 1'b0;
    if (reset) begin
      pipe_sel  = 1'b0;
      debug_sel = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pipeRequest && debugRequest) begin
            if (last_grant == SIDE_DEBUG) begin
              pipe_sel = 1'b1;
            end else begin
              debug_sel = 1'b1;
            end
          end else if (pipeRequest) begin
            pipe_sel = 1'b1;
          end else if (debugRequest) begin
            debug_sel = 1'b1;
          end else begin
            pipe_sel  = 1'b0;
            debug_sel = 1'b0;
          end
        end
        LOCKED: begin
          // Debug dropping out releases the lock and lets the pipeline in immediately.
          if (!debugRequest) begin
            pipe_sel = pipeRequest;
          end else if (pipeRequest && (lock_count == LIMIT)) begin
            pipe_sel = 1'b1;
          end else begin
            debug_sel = 1'b1;
          end
        end
        default: begin
          pipe_sel  = 1'b0;
          debug_sel = 1'b0;
        end
      endcase
    end
  end

  assign pipeGrant  = pipe_sel;
  assign debugGrant = debug_sel;

  // Memory-side mux; with no grant everything is zero so nothing can be written.
  always_comb begin
    memAddress           = 32'h0000_0000;
    memWriteType         = 2'd0;
    memExtractExtendType = 3'd0;
    memDataWrite         = 32'h0000_0000;
    if (pipe_sel) begin
      memAddress           = pipeAddress;
      memWriteType         = pipeWriteType;
      memExtractExtendType = pipeExtractExtendType;
      memDataWrite         = pipeDataWrite;
    end else if (debug_sel) begin
      memAddress           = debugAddress;
      memWriteType         = debugWriteType;
      memExtractExtendType = debugExtractExtendType;
      memDataWrite         = debugDataWrite;
    end else begin
      memAddress           = 32'h0000_0000;
      memWriteType         = 2'd0;
      memExtractExtendType = 3'd0;
      memDataWrite         = 32'h0000_0000;
    end
  end

  // Arbitration state: lock FSM, round-robin history and lock-duration counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= SIDE_DEBUG;
      lock_count <= {LOCK_COUNT_WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (debug_sel) begin
            last_grant <= SIDE_DEBUG;
            if (debugLock) begin
              state      <= LOCKED;
              lock_count <= {LOCK_COUNT_WIDTH{1'b0}};
            end else begin
              state <= IDLE;
            end
          end else if (pipe_sel) begin
            last_grant <= SIDE_PIPE;
          end else begin
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (!debugRequest) begin
            state <= IDLE;
            if (pipe_sel) begin
              last_grant <= SIDE_PIPE;
            end else begin
              last_grant <= last_grant;
            end
          end else if (pipe_sel) begin
            // Starvation relief slot: the lock survives, the budget restarts.
            last_grant <= SIDE_PIPE;
            lock_count <= {LOCK_COUNT_WIDTH{1'b0}};
          end else begin
            last_grant <= SIDE_DEBUG;
            if (!debugLock) begin
              state <= IDLE;
            end else begin
              state <= LOCKED;
            end
            if (pipeRequest && (lock_count != LIMIT)) begin
              lock_count <= lock_count + ONE;
            end else begin
              lock_count <= lock_count;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Registered responses: the granted side sees valid and captured read data next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipeResponseValid  <= 1'b0;
      debugResponseValid <= 1'b0;
      pipeDataRead       <= 32'h0000_0000;
      debugDataRead      <= 32'h0000_0000;
    end else begin
      pipeResponseValid  <= pipe_sel;
      debugResponseValid <= debug_sel;
      if (pipe_sel) begin
        pipeDataRead <= memDataRead;
      end else begin
        pipeDataRead <= pipeDataRead;
      end
      if (debug_sel) begin
        debugDataRead <= memDataRead;
      end else begin
        debugDataRead <= debugDataRead;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed table-driven bench for data_memory_arbiter (LOCK_LIMIT = 4) with a word-addressed memory model.
module tb_data_memory_arbiter;

  localparam logic [31:0] A = 32'h1111_1111;
  localparam logic [31:0] B = 32'h2222_2222;
  localparam logic [31:0] C = 32'hA5A5_A5A5;
  localparam logic [31:0] D = 32'hDEAD_BEEF;
  localparam logic [31:0] PIPE_WDATA  = 32'hDEAD_BEEF;
  localparam logic [31:0] DEBUG_WDATA = 32'h0BAD_F00D;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipeRequest, debugRequest, debugLock;
  logic [31:0] pipeAddress, debugAddress, pipeDataWrite, debugDataWrite;
  logic [1:0]  pipeWriteType, debugWriteType;
  logic [2:0]  pipeExtractExtendType, debugExtractExtendType;
  logic        pipeGrant, debugGrant, pipeResponseValid, debugResponseValid;
  logic [31:0] pipeDataRead, debugDataRead;
  logic [31:0] memAddress, memDataWrite, memDataRead;
  logic [1:0]  memWriteType;
  logic [2:0]  memExtractExtendType;

  logic [31:0] mem_model [16];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        preq;
    logic [31:0] paddr;
    logic [1:0]  pwt;
    logic        dreq;
    logic [31:0] daddr;
    logic        dlock;
    logic        e_pg;
    logic        e_dg;
    logic [31:0] e_maddr;
    logic        e_prv;
    logic        e_drv;
    logic [31:0] e_pdr;
    logic [31:0] e_ddr;
  } vec_t;

  vec_t vecs [32];

  data_memory_arbiter #(.LOCK_LIMIT(4), .LOCK_COUNT_WIDTH(3)) dut (
    .clock(clock), .reset(reset),
    .pipeRequest(pipeRequest), .pipeAddress(pipeAddress), .pipeWriteType(pipeWriteType),
    .pipeExtractExtendType(pipeExtractExtendType), .pipeDataWrite(pipeDataWrite),
    .pipeGrant(pipeGrant), .pipeResponseValid(pipeResponseValid), .pipeDataRead(pipeDataRead),
    .debugRequest(debugRequest), .debugAddress(debugAddress), .debugWriteType(debugWriteType),
    .debugExtractExtendType(debugExtractExtendType), .debugDataWrite(debugDataWrite),
    .debugLock(debugLock), .debugGrant(debugGrant), .debugResponseValid(debugResponseValid),
    .debugDataRead(debugDataRead), .memAddress(memAddress), .memWriteType(memWriteType),
    .memExtractExtendType(memExtractExtendType), .memDataWrite(memDataWrite),
    .memDataRead(memDataRead)
  );

  always #5 clock = ~clock;

  assign memDataRead = mem_model[memAddress[5:2]];

  // Memory model: preloaded while reset is high, word stores only.
  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) mem_model[k] <= 32'h0000_0000;
      mem_model[0] <= A;
      mem_model[1] <= B;
      mem_model[4] <= C;
    end else if (memWriteType == 2'd3) begin
      mem_model[memAddress[5:2]] <= memDataWrite;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic preq, input logic [31:0] paddr, input logic [1:0] pwt,
                              input logic dreq, input logic [31:0] daddr, input logic dlock,
                              input logic pg, input logic dg, input logic [31:0] maddr,
                              input logic prv, input logic drv,
                              input logic [31:0] pdr, input logic [31:0] ddr);
    vec_t v;
    v.preq = preq; v.paddr = paddr; v.pwt = pwt;
    v.dreq = dreq; v.daddr = daddr; v.dlock = dlock;
    v.e_pg = pg; v.e_dg = dg; v.e_maddr = maddr;
    v.e_prv = prv; v.e_drv = drv; v.e_pdr = pdr; v.e_ddr = ddr;
    return v;
  endfunction

  task automatic drive(input logic preq, input logic [31:0] paddr, input logic [1:0] pwt,
                       input logic dreq, input logic [31:0] daddr, input logic dlock);
    pipeRequest = preq; pipeAddress = paddr; pipeWriteType = pwt;
    pipeExtractExtendType = 3'd2; pipeDataWrite = PIPE_WDATA;
    debugRequest = dreq; debugAddress = daddr; debugWriteType = 2'd0;
    debugExtractExtendType = 3'd4; debugDataWrite = DEBUG_WDATA; debugLock = dlock;
  endtask

  task automatic run_row(input int i);
    vec_t v;
    logic [1:0]  e_mwt;
    logic [2:0]  e_mext;
    logic [31:0] e_mdw;
    v = vecs[i];
    @(negedge clock);
    drive(v.preq, v.paddr, v.pwt, v.dreq, v.daddr, v.dlock);
    #1;
    e_mwt  = v.e_pg ? v.pwt : 2'd0;
    e_mext = v.e_pg ? 3'd2 : (v.e_dg ? 3'd4 : 3'd0);
    e_mdw  = v.e_pg ? PIPE_WDATA : (v.e_dg ? DEBUG_WDATA : 32'h0000_0000);
    check($sformatf("row%0d pipeGrant", i), {31'd0, pipeGrant}, {31'd0, v.e_pg});
    check($sformatf("row%0d debugGrant", i), {31'd0, debugGrant}, {31'd0, v.e_dg});
    check($sformatf("row%0d memWriteType", i), {30'd0, memWriteType}, {30'd0, e_mwt});
    check($sformatf("row%0d memExtract", i), {29'd0, memExtractExtendType}, {29'd0, e_mext});
    check($sformatf("row%0d memAddress", i), memAddress, v.e_maddr);
    check($sformatf("row%0d memDataWrite", i), memDataWrite, e_mdw);
    check($sformatf("row%0d pipeRespValid", i), {31'd0, pipeResponseValid}, {31'd0, v.e_prv});
    check($sformatf("row%0d debugRespValid", i), {31'd0, debugResponseValid}, {31'd0, v.e_drv});
    check($sformatf("row%0d pipeDataRead", i), pipeDataRead, v.e_pdr);
    check($sformatf("row%0d debugDataRead", i), debugDataRead, v.e_ddr);
  endtask

  initial begin
    // Idle, round-robin conflict, word store/readback, lock hold, lock limit, locked debug drop.
    vecs[0]  = mk(1'b0, 32'h0,  2'd0, 1'b0, 32'h0, 1'b0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0);
    vecs[1]  = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0);
    vecs[2]  = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b0,  1'b0, 1'b1, 32'h4,  1'b1, 1'b0, A, 32'h0);
    vecs[3]  = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, A, B);
    vecs[4]  = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b0,  1'b0, 1'b1, 32'h4,  1'b1, 1'b0, A, B);
    vecs[5]  = mk(1'b0, 32'h0,  2'd0, 1'b0, 32'h0, 1'b0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b1, A, B);
    for (int k = 6; k <= 8; k++)
      vecs[k] = mk(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, A, B);
    vecs[9]  = mk(1'b1, 32'h10, 2'd3, 1'b0, 32'h0, 1'b0,  1'b1, 1'b0, 32'h10, 1'b0, 1'b0, A, B);
    vecs[10] = mk(1'b0, 32'h0,  2'd0, 1'b0, 32'h0, 1'b0,  1'b0, 1'b0, 32'h0,  1'b1, 1'b0, C, B);
    vecs[11] = mk(1'b1, 32'h10, 2'd0, 1'b0, 32'h0, 1'b0,  1'b1, 1'b0, 32'h10, 1'b0, 1'b0, C, B);
    vecs[12] = mk(1'b0, 32'h0,  2'd0, 1'b0, 32'h0, 1'b0,  1'b0, 1'b0, 32'h0,  1'b1, 1'b0, D, B);
    vecs[13] = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b1,  1'b0, 1'b1, 32'h4,  1'b0, 1'b0, D, B);
    vecs[14] = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b1,  1'b0, 1'b1, 32'h4,  1'b0, 1'b1, D, B);
    vecs[15] = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b0,  1'b0, 1'b1, 32'h4,  1'b0, 1'b1, D, B);
    vecs[16] = mk(1'b1, 32'h0,  2'd0, 1'b0, 32'h0, 1'b0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, D, B);
    vecs[17] = mk(1'b0, 32'h0,  2'd0, 1'b0, 32'h0, 1'b0,  1'b0, 1'b0, 32'h0,  1'b1, 1'b0, A, B);
    vecs[18] = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b1,  1'b0, 1'b1, 32'h4,  1'b0, 1'b0, A, B);
    for (int k = 19; k <= 22; k++)
      vecs[k] = mk(1'b1, 32'h0, 2'd0, 1'b1, 32'h4, 1'b1,  1'b0, 1'b1, 32'h4,  1'b0, 1'b1, A, B);
    vecs[23] = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b1,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, A, B);
    vecs[24] = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b1,  1'b0, 1'b1, 32'h4,  1'b1, 1'b0, A, B);
    for (int k = 25; k <= 27; k++)
      vecs[k] = mk(1'b1, 32'h0, 2'd0, 1'b1, 32'h4, 1'b1,  1'b0, 1'b1, 32'h4,  1'b0, 1'b1, A, B);
    vecs[28] = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b1,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, A, B);
    vecs[29] = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b1,  1'b0, 1'b1, 32'h4,  1'b1, 1'b0, A, B);
    vecs[30] = mk(1'b1, 32'h0,  2'd0, 1'b0, 32'h0, 1'b0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, A, B);
    vecs[31] = mk(1'b1, 32'h0,  2'd0, 1'b1, 32'h4, 1'b1,  1'b0, 1'b1, 32'h4,  1'b1, 1'b0, A, B);

    // Reset state: grants held low even with both sides requesting.
    reset = 1'b1;
    drive(1'b1, 32'h0, 2'd3, 1'b1, 32'h4, 1'b1);
    @(negedge clock);
    #1;
    check("reset pipeGrant", {31'd0, pipeGrant}, 32'd0);
    check("reset debugGrant", {31'd0, debugGrant}, 32'd0);
    check("reset memWriteType", {30'd0, memWriteType}, 32'd0);
    check("reset pipeRespValid", {31'd0, pipeResponseValid}, 32'd0);
    check("reset debugRespValid", {31'd0, debugResponseValid}, 32'd0);
    check("reset pipeDataRead", pipeDataRead, 32'd0);
    @(negedge clock);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) run_row(i);

    // Asynchronous reset between edges while locked with a debug response pending.
    @(negedge clock);
    drive(1'b1, 32'h0, 2'd0, 1'b1, 32'h4, 1'b1);
    #1;
    check("prelock debugRespValid", {31'd0, debugResponseValid}, 32'd1);
    check("prelock debugGrant", {31'd0, debugGrant}, 32'd1);
    check("prelock pipeGrant", {31'd0, pipeGrant}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("midreset debugRespValid", {31'd0, debugResponseValid}, 32'd0);
    check("midreset pipeRespValid", {31'd0, pipeResponseValid}, 32'd0);
    check("midreset debugGrant", {31'd0, debugGrant}, 32'd0);
    check("midreset pipeGrant", {31'd0, pipeGrant}, 32'd0);
    check("midreset memWriteType", {30'd0, memWriteType}, 32'd0);
    check("midreset debugDataRead", debugDataRead, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 32'h0, 2'd0, 1'b1, 32'h4, 1'b1);
    #1;
    check("post-reset conflict pipeGrant", {31'd0, pipeGrant}, 32'd1);
    check("post-reset conflict debugGrant", {31'd0, debugGrant}, 32'd0);
    @(negedge clock);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    #1;
    check("post-reset pipeRespValid", {31'd0, pipeResponseValid}, 32'd1);
    check("post-reset pipeDataRead", pipeDataRead, A);
    check("post-reset debugRespValid", {31'd0, debugResponseValid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
